// File: rtl/cipher_bus_master_if.sv
// AES cipher bus bundle: host request/response streams, core-side issue/result
// bus, and status outputs. master = cipher_bus_master view, slave = environment view.
interface cipher_bus_master_if #(
  parameter int MAX_OUTST = 4
);
  logic                           req_valid;
  logic                           req_ready;
  logic [127:0]                   req_data;
  logic                           req_ende;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [127:0]                   rsp_data;
  logic                           rsp_ende;
  logic                           i_enable;
  logic                           i_ende;
  logic [127:0]                   i_data;
  logic                           i_data_valid;
  logic                           o_ready;
  logic                           o_data_valid;
  logic [127:0]                   o_data;
  logic [$clog2(MAX_OUTST+1)-1:0] outstanding;
  logic                           err_unexp;

  modport master (
    input  req_valid, req_data, req_ende, rsp_ready, o_ready, o_data_valid, o_data,
    output req_ready, rsp_valid, rsp_data, rsp_ende,
    output i_enable, i_ende, i_data, i_data_valid, outstanding, err_unexp
  );

  modport slave (
    output req_valid, req_data, req_ende, rsp_ready, o_ready, o_data_valid, o_data,
    input  req_ready, rsp_valid, rsp_data, rsp_ende,
    input  i_enable, i_ende, i_data, i_data_valid, outstanding, err_unexp
  );
endinterface

// File: rtl/cipher_bus_master.sv
// Initiator end of the AES cipher bus: buffers host blocks, issues them to the core
// under credit and mode-switch rules, and returns in-order results to the host.
module cipher_bus_master #(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int MAX_OUTST = 4
) (
  input logic                 clk,
  input logic                 resetH,
  cipher_bus_master_if.master bus
);
  localparam int QA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);
  localparam int OW = $clog2(MAX_OUTST + 1);

  localparam logic [QA:0]   REQ_ONE   = 1;
  localparam logic [SA:0]   RSP_ONE   = 1;
  localparam logic [OW-1:0] OUT_ONE   = 1;
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [128:0]  req_mem_q [REQ_DEPTH];
  logic [128:0]  rsp_mem_q [RSP_DEPTH];
  logic [QA:0]   req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [SA:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [SA:0]   rsp_cnt;
  logic [OW-1:0] outst_q, outst_d;
  logic [1:0]    state_q, state_d;
  logic          cur_ende_q, cur_ende_d;
  logic [127:0]  i_data_q, i_data_d;
  logic          i_dv_q, i_dv_d;
  logic          i_en_q;
  logic          err_q, err_d;

  logic          req_empty, req_full, req_push, req_empty_next;
  logic          rsp_nempty, rsp_pop;
  logic [128:0]  req_head, rsp_head;
  logic          run_ok, credit_ok, mode_ok, issue;
  logic          capture, unexp;

  assign req_empty = (req_wr_q == req_rd_q);
  assign req_full  = (req_wr_q[QA] != req_rd_q[QA]) && (req_wr_q[QA-1:0] == req_rd_q[QA-1:0]);
  assign req_head  = req_mem_q[req_rd_q[QA-1:0]];
  assign req_push  = bus.req_valid && bus.req_ready;

  assign rsp_cnt    = rsp_wr_q - rsp_rd_q;
  assign rsp_nempty = (rsp_wr_q != rsp_rd_q);
  assign rsp_head   = rsp_mem_q[rsp_rd_q[SA-1:0]];
  assign rsp_pop    = rsp_nempty && bus.rsp_ready;

  // A result slot is reserved at issue time, so captures can never hit a full response FIFO.
  assign run_ok    = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && (outst_q == '0));
  assign credit_ok = (outst_q < OUTST_MAX) && ((32'(outst_q) + 32'(rsp_cnt)) < RSP_DEPTH);
  assign mode_ok   = (req_head[0] == cur_ende_q) || (outst_q == '0);
  assign issue     = run_ok && !req_empty && bus.o_ready && credit_ok && mode_ok;

  assign capture = bus.o_data_valid && (outst_q != '0);
  assign unexp   = bus.o_data_valid && (outst_q == '0);

  assign bus.req_ready    = !req_full && !resetH;
  assign bus.rsp_valid    = rsp_nempty;
  assign bus.rsp_data     = rsp_nempty ? rsp_head[128:1] : '0;
  assign bus.rsp_ende     = rsp_nempty ? rsp_head[0] : 1'b0;
  assign bus.i_enable     = i_en_q;
  assign bus.i_ende       = cur_ende_q;
  assign bus.i_data       = i_data_q;
  assign bus.i_data_valid = i_dv_q;
  assign bus.outstanding  = outst_q;
  assign bus.err_unexp    = err_q;

  always_comb begin
    req_wr_d   = req_push ? req_wr_q + REQ_ONE : req_wr_q;
    req_rd_d   = issue    ? req_rd_q + REQ_ONE : req_rd_q;
    rsp_wr_d   = capture  ? rsp_wr_q + RSP_ONE : rsp_wr_q;
    rsp_rd_d   = rsp_pop  ? rsp_rd_q + RSP_ONE : rsp_rd_q;
    cur_ende_d = issue ? req_head[0]      : cur_ende_q;
    i_data_d   = issue ? req_head[128:1]  : i_data_q;
    i_dv_d     = issue;
    err_d      = err_q | unexp;
    outst_d    = outst_q;
    if (issue && !capture) begin
      outst_d = outst_q + OUT_ONE;
    end else if (!issue && capture) begin
      outst_d = outst_q - OUT_ONE;
    end
  end

  assign req_empty_next = (req_wr_d == req_rd_d);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!req_empty) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (req_empty_next) begin
          state_d = ST_IDLE;
        end else if (!issue && (req_head[0] != cur_ende_q) && (outst_q != '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Re-entry to RUN shares the edge with the first issue of the new mode.
        if (outst_q == '0) state_d = req_empty_next ? ST_IDLE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetH) begin
      req_wr_q   <= '0;
      req_rd_q   <= '0;
      rsp_wr_q   <= '0;
      rsp_rd_q   <= '0;
      outst_q    <= '0;
      state_q    <= ST_IDLE;
      cur_ende_q <= 1'b0;
      i_data_q   <= '0;
      i_dv_q     <= 1'b0;
      i_en_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      req_wr_q   <= req_wr_d;
      req_rd_q   <= req_rd_d;
      rsp_wr_q   <= rsp_wr_d;
      rsp_rd_q   <= rsp_rd_d;
      outst_q    <= outst_d;
      state_q    <= state_d;
      cur_ende_q <= cur_ende_d;
      i_data_q   <= i_data_d;
      i_dv_q     <= i_dv_d;
      i_en_q     <= 1'b1;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_push) req_mem_q[req_wr_q[QA-1:0]] <= {bus.req_data, bus.req_ende};
    if (capture)  rsp_mem_q[rsp_wr_q[SA-1:0]] <= {bus.o_data, cur_ende_q};
  end
endmodule
